// File: rtl/clock_mode_ctrl_if.sv
// Button inputs and mode/enable outputs of the clock mode controller.
// The master side drives the raw buttons and observes the controller.
interface clock_mode_ctrl_if;
    logic       mode_n;
    logic [3:0] key_n;
    logic [3:0] key_db_n;
    logic       enaclk;
    logic       enaset;
    logic       enastp;
    logic       enactd;
    logic [1:0] mode;
    logic       running;

    modport master (
        output mode_n, key_n,
        input  key_db_n, enaclk, enaset, enastp, enactd, mode, running
    );

    modport slave (
        input  mode_n, key_n,
        output key_db_n, enaclk, enaset, enastp, enactd, mode, running
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Debounces the mode and key buttons and sequences CLK/SET/STP/CTD modes,
// producing mutually exclusive registered enables for the time counter.
module clock_mode_ctrl #(
    parameter int DEB_CYCLES = 540000
) (
    input logic              clk,
    input logic              rstn,
    clock_mode_ctrl_if.slave io
);
    localparam int            CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        M_CLK = 2'b00,
        M_SET = 2'b01,
        M_STP = 2'b10,
        M_CTD = 2'b11
    } mode_t;

    // bit 4 is the mode button, bits 3..0 are key3..key0
    logic [4:0]         raw;
    logic [4:0]         s1;
    logic [4:0]         s2;
    logic [4:0]         db;
    logic [4:0]         fall;
    logic [4:0][CW-1:0] cnt;

    mode_t st;
    mode_t nst;
    logic  running;
    logic  nrun;
    logic  enaclk;
    logic  enaset;
    logic  enastp;
    logic  enactd;

    assign raw = {io.mode_n, io.key_n};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // a level is accepted after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db   <= '1;
            cnt  <= '0;
            fall <= '0;
        end else begin
            fall <= '0;
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    db[i]   <= s2[i];
                    cnt[i]  <= '0;
                    fall[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // a mode press overrides a simultaneous run toggle
    always_comb begin
        nst  = st;
        nrun = running;
        if (fall[4]) begin
            nst  = mode_t'(st + 2'd1);
            nrun = 1'b0;
        end else if (fall[0] && st[1]) begin
            nrun = ~running;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st      <= M_CLK;
            running <= 1'b0;
            enaclk  <= 1'b1;
            enaset  <= 1'b0;
            enastp  <= 1'b0;
            enactd  <= 1'b0;
        end else begin
            st      <= nst;
            running <= nrun;
            enaclk  <= (nst == M_CLK);
            enaset  <= (nst == M_SET);
            enastp  <= (nst == M_STP) && nrun;
            enactd  <= (nst == M_CTD) && nrun;
        end
    end

    assign io.key_db_n = db[3:0];
    assign io.mode     = st;
    assign io.running  = running;
    assign io.enaclk   = enaclk;
    assign io.enaset   = enaset;
    assign io.enastp   = enastp;
    assign io.enactd   = enactd;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with DEB_CYCLES=4.
// Expected values are hand-derived from sync + debounce latency.
module tb_clock_mode_ctrl;
    logic clk;
    logic rstn;
    int   nvec;
    int   nerr;
    int   viol;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.DEB_CYCLES(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // more than one enable high in any cycle is a violation
    always @(negedge clk) begin
        if ($countones({bus.enaclk, bus.enaset, bus.enastp, bus.enactd}) > 1)
            viol++;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        bus.mode_n = 1'b0;
        idle(6);
        bus.mode_n = 1'b1;
        idle(10);
    endtask

    task automatic press_key0();
        bus.key_n[0] = 1'b0;
        idle(6);
        bus.key_n[0] = 1'b1;
        idle(10);
    endtask

    task automatic press_both();
        bus.mode_n   = 1'b0;
        bus.key_n[0] = 1'b0;
        idle(6);
        bus.mode_n   = 1'b1;
        bus.key_n[0] = 1'b1;
        idle(10);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        viol = 0;
        rstn = 1'b0;
        bus.mode_n = 1'b0;
        bus.key_n  = 4'h0;
        idle(3);
        chk("rst_mode", 8'(bus.mode), 8'h0);
        chk("rst_enaclk", 8'(bus.enaclk), 8'h1);
        chk("rst_others", 8'({bus.enaset, bus.enastp, bus.enactd}), 8'h0);
        chk("rst_keydb", 8'(bus.key_db_n), 8'hf);
        chk("rst_running", 8'(bus.running), 8'h0);
        bus.mode_n = 1'b1;
        bus.key_n  = 4'hf;
        idle(2);
        rstn = 1'b1;
        idle(4);

        // 3-cycle glitch is rejected
        bus.mode_n = 1'b0;
        idle(3);
        bus.mode_n = 1'b1;
        idle(10);
        chk("glitch_mode", 8'(bus.mode), 8'h0);
        chk("glitch_enaclk", 8'(bus.enaclk), 8'h1);

        // 2 sync + 4 debounce + 1 fsm edges
        bus.mode_n = 1'b0;
        idle(6);
        chk("deb_early", 8'(bus.mode), 8'h0);
        bus.mode_n = 1'b1;
        idle(1);
        chk("deb_mode", 8'(bus.mode), 8'h1);
        chk("deb_enaset", 8'(bus.enaset), 8'h1);
        chk("deb_enaclk", 8'(bus.enaclk), 8'h0);
        idle(10);
        chk("deb_once", 8'(bus.mode), 8'h1);

        bus.key_n = 4'b1011;
        idle(5);
        chk("pass_early", 8'(bus.key_db_n), 8'hf);
        idle(1);
        chk("pass_keydb", 8'(bus.key_db_n), 8'hb);
        chk("pass_mode", 8'(bus.mode), 8'h1);
        bus.key_n = 4'hf;
        idle(10);
        chk("pass_release", 8'(bus.key_db_n), 8'hf);

        press_key0();
        chk("set_key0_run", 8'(bus.running), 8'h0);
        chk("set_key0_mode", 8'(bus.mode), 8'h1);

        press_mode();
        chk("stp_mode", 8'(bus.mode), 8'h2);
        chk("stp_idle_en", 8'({bus.enaclk, bus.enaset, bus.enastp}), 8'h0);
        press_key0();
        chk("stp_run", 8'({bus.running, bus.enastp}), 8'h3);
        press_key0();
        chk("stp_stop", 8'({bus.running, bus.enastp}), 8'h0);
        press_key0();
        chk("stp_run2", 8'(bus.running), 8'h1);
        press_mode();
        chk("ctd_mode", 8'(bus.mode), 8'h3);
        chk("ctd_cleared", 8'({bus.running, bus.enactd}), 8'h0);

        press_mode();
        chk("wrap_mode", 8'(bus.mode), 8'h0);
        chk("wrap_enaclk", 8'(bus.enaclk), 8'h1);
        press_mode();
        press_mode();
        chk("back_stp", 8'(bus.mode), 8'h2);

        press_both();
        chk("both_mode", 8'(bus.mode), 8'h3);
        chk("both_run", 8'({bus.running, bus.enactd}), 8'h0);
        press_key0();
        chk("ctd_run", 8'({bus.running, bus.enactd}), 8'h3);

        // reset mid-run with the mode button held through release
        bus.mode_n = 1'b0;
        idle(1);
        rstn = 1'b0;
        #1;
        chk("arst_mode", 8'(bus.mode), 8'h0);
        chk("arst_en",
            8'({bus.enaclk, bus.enaset, bus.enastp, bus.enactd, bus.running}),
            8'h10);
        idle(2);
        rstn = 1'b1;
        idle(6);
        chk("held_early", 8'(bus.mode), 8'h0);
        idle(1);
        chk("held_press", 8'(bus.mode), 8'h1);
        bus.mode_n = 1'b1;
        idle(10);
        chk("held_once", 8'(bus.mode), 8'h1);

        chk("onehot", 8'(viol), 8'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 540000, consecutive stable cycles required to accept a key change (20 ms at 27 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 27 MHz.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mode_n  input  1  raw mode push-button, active-low, asynchronous to clk.
REQ-005 SHALL have port key_n  input  4  raw push-buttons key3..key0, active-low, asynchronous to clk.
REQ-006 SHALL have port key_db_n  output  4  debounced key levels, active-low, driving the time counter key0..key3 inputs.
REQ-007 SHALL have port enaclk  output  1  clock counting enable.
REQ-008 SHALL have port enaset  output  1  time setting enable.
REQ-009 SHALL have port enastp  output  1  stopwatch counting enable.
REQ-010 SHALL have port enactd  output  1  countdown enable.
REQ-011 SHALL have port mode  output  2  current mode: 00 CLK, 01 SET, 10 STP, 11 CTD.
REQ-012 SHALL have port running  output  1  run flag for STP/CTD modes.

Function
REQ-013 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep per input a debounced level and a counter of width ceil(log2(DEB_CYCLES+1)); counter clears whenever synchronized value equals debounced level.
REQ-015 SHALL increment the counter each cycle synchronized value differs from debounced level; on reaching DEB_CYCLES-1, debounced level takes synchronized value and counter clears next cycle.
REQ-016 SHALL generate an internal one-cycle press pulse on each debounced 1->0 transition; releases generate no pulse.
REQ-017 SHALL drive key_db_n directly from the debounced key levels, in all modes.
REQ-018 SHALL implement a 4-state mode FSM CLK->SET->STP->CTD->CLK, advancing exactly one state per mode press pulse, transition registered on the cycle after the pulse.
REQ-019 SHALL clear running on every mode transition.
REQ-020 SHALL toggle running on a key0 press pulse only when mode is STP or CTD; key0 presses in CLK/SET do not affect running.
REQ-021 SHALL, on simultaneous mode press and key0 press pulses, apply the mode transition and clear running (mode wins).
REQ-022 SHALL drive enables as registered, mutually exclusive: enaclk = (mode==CLK); enaset = (mode==SET); enastp = (mode==STP)&running; enactd = (mode==CTD)&running.
REQ-023 SHALL never assert more than one enable in any cycle, including the cycle of a mode change.
REQ-024 SHALL update enables in the same cycle mode/running update (one cycle after the press pulse).
REQ-025 SHALL treat glitches shorter than DEB_CYCLES synchronized cycles as no change (no pulse, no level change).

Reset
REQ-026 SHALL, while rstn low, force: synchronizer flops and debounced levels 1 (released), counters 0, mode 00, running 0, enaclk 1, enaset/enastp/enactd 0, key_db_n 4'b1111.
REQ-027 SHALL, on rstn assertion mid-debounce or mid-run, abandon all progress immediately; a button held through reset release is re-debounced and yields one press pulse after DEB_CYCLES.

Verification (DEB_CYCLES=4)
REQ-028 SHALL verify reset: rstn low with keys held -> mode=00, enaclk=1, others 0, key_db_n=1111, running=0.
REQ-029 SHALL verify debounce: mode_n low for 3 synchronized cycles then high -> no mode change; low for 6 cycles -> exactly one advance 00->01.
REQ-030 SHALL verify mode wrap: 4 clean mode presses -> mode sequence 01,10,11,00; enaset high only in 01; enaclk high again at 00.
REQ-031 SHALL verify stopwatch run: in STP, key0 press -> running=1, enastp=1; second press -> both 0; mode press while running -> mode=11, running=0, enactd=0.
REQ-032 SHALL verify simultaneous press: in STP with running=0, mode_n and key_n[0] fall same cycle -> mode=11, running=0.
REQ-033 SHALL verify passthrough: in SET, key_n=1011 held 6 cycles -> key_db_n=1011 after synchronizer+DEB_CYCLES latency, mode unchanged.
